// File: rtl/syscfg_regfile_if.sv
// APB3 slave-side bus bundle for syscfg_regfile.
interface syscfg_regfile_if;
  logic [15:0] apb_addr;
  logic        apb_selx;
  logic        apb_enable;
  logic        apb_write;
  logic [31:0] apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;
  logic        apb_slverr;

  modport master (
    output apb_addr, apb_selx, apb_enable, apb_write, apb_wdata,
    input  apb_ready, apb_rdata, apb_slverr
  );

  modport slave (
    input  apb_addr, apb_selx, apb_enable, apb_write, apb_wdata,
    output apb_ready, apb_rdata, apb_slverr
  );
endinterface

// File: rtl/syscfg_regfile.sv
// APB3 system-configuration register file: VERSION, IRQ status/mask,
// NUM_RW config words driven out, NUM_RO status words sampled in.
// Programmable wait states; PSLVERR on unmapped accesses and RO writes.

// One 32-bit config word with write enable.
module syscfg_cfg_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] q
);
  // Config word storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= wdata;
  end
endmodule

module syscfg_regfile #(
  parameter int AWID_USE    = 8,
  parameter int NUM_RW      = 4,
  parameter int NUM_RO      = 2,
  parameter int IRQ_WID     = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  syscfg_regfile_if.slave         apb,
  input  logic [31:0]             syscfg_version,
  input  logic [NUM_RO-1:0][31:0] sts_in,
  output logic [NUM_RW-1:0][31:0] cfg_out,
  input  logic [IRQ_WID-1:0]      irq_event,
  output logic                    irq
);

  localparam int IDX_W = AWID_USE - 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 ready_nxt, slverr_nxt;
  logic [31:0]          rdata_nxt;
  logic                 commit;

  logic [31:0]          idx;
  logic [31:0]          rd_data;
  logic                 rd_map, rd_ro, acc_err;

  logic [IRQ_WID-1:0]   irq_status, irq_mask, irq_clr;

  // Bits outside the decoded window are deliberately ignored.
  logic unused_addr;
  assign unused_addr = &{1'b0, apb.apb_addr[15:AWID_USE], apb.apb_addr[1:0]};

  // Word index, zero-extended so it compares cleanly against map offsets.
  assign idx = {{(32-IDX_W){1'b0}}, apb.apb_addr[AWID_USE-1:2]};

  // Address decode and read mux; rd_ro marks registers that reject writes.
  always_comb begin
    rd_data = '0;
    rd_map  = 1'b0;
    rd_ro   = 1'b0;
    if (idx == 32'd0) begin
      rd_data = syscfg_version;
      rd_map  = 1'b1;
      rd_ro   = 1'b1;
    end else if (idx == 32'd1) begin
      rd_data[IRQ_WID-1:0] = irq_status;
      rd_map  = 1'b1;
    end else if (idx == 32'd2) begin
      rd_data[IRQ_WID-1:0] = irq_mask;
      rd_map  = 1'b1;
    end
    for (int i = 0; i < NUM_RW; i++) begin
      if (idx == 32'(3 + i)) begin
        rd_data = cfg_out[i];
        rd_map  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (idx == 32'(3 + NUM_RW + j)) begin
        rd_data = sts_in[j];
        rd_map  = 1'b1;
        rd_ro   = 1'b1;
      end
    end
  end

  assign acc_err = !rd_map || (apb.apb_write && rd_ro);

  // FSM state, wait counter and registered APB response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      apb.apb_ready  <= 1'b1;
      apb.apb_rdata  <= '0;
      apb.apb_slverr <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      apb.apb_ready  <= ready_nxt;
      apb.apb_rdata  <= rdata_nxt;
      apb.apb_slverr <= slverr_nxt;
    end
  end

  // Transfer sequencing: setup -> wait states -> completion/commit.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ready_nxt  = apb.apb_ready;
    rdata_nxt  = apb.apb_rdata;
    slverr_nxt = apb.apb_slverr;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (apb.apb_selx && !apb.apb_enable) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
          ready_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (!apb.apb_selx) begin
          // Master abandoned the transfer: release the bus, no write.
          state_nxt = IDLE;
          ready_nxt = 1'b1;
        end else if (cnt == 4'd0) begin
          state_nxt  = DONE;
          ready_nxt  = 1'b1;
          rdata_nxt  = acc_err ? 32'd0 : rd_data;
          slverr_nxt = acc_err;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        slverr_nxt = 1'b0;
        commit     = apb.apb_selx && apb.apb_enable && apb.apb_write && !acc_err;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // W1C clear mask for this cycle; a same-cycle event still sets the bit.
  always_comb begin
    irq_clr = '0;
    if (commit && idx == 32'd1) irq_clr = apb.apb_wdata[IRQ_WID-1:0];
  end

  // Interrupt status (set beats clear) and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
      irq_mask   <= '0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | irq_event;
      if (commit && idx == 32'd2) irq_mask <= apb.apb_wdata[IRQ_WID-1:0];
    end
  end

  assign irq = |(irq_status & irq_mask);

  for (genvar i = 0; i < NUM_RW; i++) begin : g_cfg
    syscfg_cfg_reg u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (commit && idx == 32'(3 + i)),
      .wdata (apb.apb_wdata),
      .q     (cfg_out[i])
    );
  end

endmodule

// File: doc/syscfg_regfile.md
# syscfg_regfile

Parametrised APB3 system-configuration register file, successor to the single-register version block. It provides a version register, `NUM_RW` read/write configuration registers driven out to the SoC, and `NUM_RO` read-only status registers sampled from the SoC. It also holds a masked, write-1-to-clear interrupt status register with a level interrupt output. Programmable wait states and `apb_slverr` signalling for illegal accesses are included. It sits on the FPGA peripheral APB bus beside the other low-speed slaves.

## Interface
- `AWID_USE`, 8, number of low `apb_addr` bits decoded; requires 3+NUM_RW+NUM_RO <= 2^(AWID_USE-2)
- `NUM_RW`, 4, number of 32-bit RW config registers (>=1)
- `NUM_RO`, 2, number of 32-bit RO status registers (>=1)
- `IRQ_WID`, 8, number of interrupt sources (1..32)
- `WAIT_CYCLES`, 0, extra wait states inserted per transfer (0..15)

Ports:
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `apb_addr` in 16 — byte address; only `[AWID_USE-1:2]` decoded, `[1:0]` ignored
- `apb_selx` in 1 — PSEL
- `apb_enable` in 1 — PENABLE
- `apb_write` in 1 — 1 = write
- `apb_wdata` in 32 — write data
- `apb_ready` out 1 — PREADY, registered
- `apb_rdata` out 32 — read data, registered
- `apb_slverr` out 1 — PSLVERR, registered, qualified by `apb_ready`
- `syscfg_version` in 32 — value returned by VERSION
- `sts_in` in 32*NUM_RO — status words; word j is `[32j+:32]`
- `cfg_out` out 32*NUM_RW — config register contents; word i is `[32i+:32]`
- `irq_event` in IRQ_WID — per-source set pulses, 1 cycle = 1 event
- `irq` out 1 — `|(IRQ_STATUS & IRQ_MASK)`

## Operation
Register map (idx = `apb_addr[AWID_USE-1:2]`):
- idx 0 VERSION, byte address 0x00: RO, `syscfg_version`
- idx 1 IRQ_STATUS, 0x04: W1C, bits `[IRQ_WID-1:0]`; upper bits read 0
- idx 2 IRQ_MASK, 0x08: RW, bits `[IRQ_WID-1:0]`; upper bits read 0 and ignore writes
- idx 3+i CFG[i], 0x0C+4i: RW, full 32 bits
- idx 3+NUM_RW+j STS[j]: RO, `sts_in` word j sampled at the read-data capture edge
- idx >= 3+NUM_RW+NUM_RO: unmapped

Error rules:
- Any unmapped access, or a write to VERSION/STS, completes with `apb_slverr`=1 and `apb_rdata`=0.
- Such a write has no side effect.
- Reads never have side effects.

Interrupts:
- A set of IRQ_STATUS bit k occurs on any cycle with `irq_event[k]`=1.
- A write to IRQ_STATUS clears each bit k where `apb_wdata[k]`=1.
- If a set and a clear hit the same bit in the same cycle, the set wins.
- `irq` is combinational from the registers and carries no extra latency.

FSM states IDLE, WAIT, DONE; counter `cnt` is 4 bits:
- IDLE: on `apb_selx`=1 and `apb_enable`=0 (setup phase), go to WAIT, load `cnt`=WAIT_CYCLES, `apb_ready`<=0.
- WAIT: if `apb_selx`=0 (aborted transfer), go to IDLE with `apb_ready`<=1 and perform no write. Else if `cnt`==0, go to DONE: `apb_ready`<=1, capture `apb_rdata` (mapped read data, otherwise 0) and `apb_slverr`. Else decrement `cnt`.
- DONE: the transfer completes this cycle (`apb_selx`&`apb_enable`&`apb_ready`). If it is a legal write, commit it at this edge. Go to IDLE; `apb_slverr`<=0.

Reset values:
- `apb_ready`=1, `apb_rdata`=0, `apb_slverr`=0
- all CFG=0, IRQ_MASK=0, IRQ_STATUS=0, `irq`=0
- FSM in IDLE

An asserted `rst_n` mid-transfer aborts the transfer immediately and drops any pending write.

## Timing
- Setup phase at cycle T. `apb_ready` is low in cycles T+1 .. T+1+WAIT_CYCLES and high in T+2+WAIT_CYCLES, where the transfer completes.
- Access phase length is WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES=0 this is the legacy 2-cycle access.
- A CFG write is visible on `cfg_out` from cycle T+3+WAIT_CYCLES.
- An IRQ_STATUS clear lowers `irq` in that same cycle, if no other masked bit is pending.
- `irq_event` at cycle E makes `irq` high at E+1 (if masked in).
- Back-to-back transfers are supported: a new setup may follow in the cycle after completion.

## Test plan
- Reset, WAIT_CYCLES=0: read 0x00 with `syscfg_version`=0x2024_0601 -> `apb_ready` low 1 cycle, then `rdata`=0x2024_0601, `slverr`=0; all `cfg_out`=0.
- Write 0xDEAD_BEEF to 0x0C, then 0x1234_5678 to 0x18 (NUM_RW=4) -> `cfg_out` word0=0xDEAD_BEEF and word3=0x1234_5678; readback matches, `slverr`=0.
- WAIT_CYCLES=3: read 0x1C (STS[0]) with `sts_in[31:0]`=0xA5A5_0003 -> `ready` low exactly 4 cycles, then `rdata`=0xA5A5_0003.
- Write mask 0x05, pulse `irq_event`=0x07 -> status reads 0x07 and `irq`=1. Write 0x05 to 0x04 -> status 0x02 and `irq`=0. Pulse bit 0 in the clearing cycle while writing 0x01 -> bit 0 remains 1.
- Write to 0x00, write to 0x20, read 0xFC -> each completes with `slverr`=1 and `rdata`=0; VERSION and `cfg_out` unchanged.
- Drop `rst_n` during WAIT of a write of 0xFFFF_FFFF to 0x0C -> `cfg_out`=0, `ready`=1, FSM IDLE; next read of 0x0C returns 0.
